div_array_sched: RTL

Sequencer and arbiter that shares one combinational 8/4 restoring array divider between two requesters. It accepts divide requests over valid/ready, arbitrates round-robin and screens divide-by-zero and quotient overflow. It drives the array operands from registers, waits a fixed settle time for the ripple-borrow path, then captures quotient and remainder into a registered response with valid/ready. It sits between the requesting blocks and the array instance.

---
 rtl/div_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 45 ++++
 rtl/div_array_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the divider sequencer slice.
//   - Operand widths for the 8/4 restoring array divider.
//   - Response error codes.
//   - Sequencer FSM state encoding.
//   - Packed response record held while the consumer stalls.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int unsigned DIVIDEND_W = 8;
  localparam int unsigned DIVISOR_W  = 4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef struct packed {
    logic                 id;
    logic [DIVISOR_W-1:0] q;
    logic [DIVISOR_W-1:0] r;
    logic [1:0]           err;
  } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. The requester that did not win last time wins a
// tie; the winner is remembered only when the grant is actually taken.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req0, i_req1    request lines
//   i_en              grant may be taken this cycle (parent is idle)
//   o_gnt_vld         at least one requester is asking
//   o_gnt             granted index (valid when o_gnt_vld)
//   o_accept          grant taken this cycle (i_en & o_gnt_vld)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_en,
  output logic o_gnt_vld,
  output logic o_gnt,
  output logic o_accept
);

  logic r_last_grant;

  always_comb begin
    o_gnt_vld = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt = ~r_last_grant;
    end else begin
      o_gnt = i_req1;
    end
    o_accept = i_en & o_gnt_vld;
  end

  // Reset to 1 so that requester 0 wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (o_accept) begin
      r_last_grant <= o_gnt;
    end
  end

endmodule

// File: rtl/div_array_sched.sv
// -----------------------------------------------------------------------------
// div_array_sched
// Shares one external combinational 8/4 restoring array divider between two
// requesters. Requests are taken over valid/ready with round-robin arbitration,
// divide-by-zero and quotient overflow are answered without using the array,
// otherwise the operands are held on the array for SETTLE_CYCLES cycles before
// quotient and remainder are captured into a registered valid/ready response.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req{0,1}_valid/_ready/_x/_y       requester handshakes and operands
//   rsp_valid/_ready/_id/_q/_r/_err   response channel
//   busy                              sequencer not idle
//   arr_x, arr_y, arr_bin             operands driven to the array
//   arr_q, arr_r                      results returned by the array
// -----------------------------------------------------------------------------
module div_array_sched
  import div_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          CHK_OVF       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DIVIDEND_W-1:0] req0_x,
  input  logic [DIVISOR_W-1:0]  req0_y,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DIVIDEND_W-1:0] req1_x,
  input  logic [DIVISOR_W-1:0]  req1_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DIVISOR_W-1:0]  rsp_q,
  output logic [DIVISOR_W-1:0]  rsp_r,
  output logic [1:0]            rsp_err,
  output logic                  busy,
  output logic [DIVIDEND_W-1:0] arr_x,
  output logic [DIVISOR_W-1:0]  arr_y,
  output logic [DIVISOR_W-1:0]  arr_bin,
  input  logic [DIVISOR_W-1:0]  arr_q,
  input  logic [DIVISOR_W-1:0]  arr_r
);

  localparam int unsigned   CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [DIVIDEND_W-1:0] r_x;
  logic [DIVISOR_W-1:0]  r_y;
  rsp_t                  r_rsp, w_rsp_nxt;

  logic                  w_idle;
  logic                  w_gnt_vld;
  logic                  w_gnt;
  logic                  w_accept;
  logic [DIVIDEND_W-1:0] w_in_x;
  logic [DIVISOR_W-1:0]  w_in_y;
  logic                  w_div0;
  logic                  w_ovf;

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign w_idle = (r_state == ST_IDLE) & ~rst;

  rr_arb2 u_arb (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req0    (req0_valid),
    .i_req1    (req1_valid),
    .i_en      (w_idle),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt     (w_gnt),
    .o_accept  (w_accept)
  );

  assign req0_ready = w_idle & w_gnt_vld & ~w_gnt;
  assign req1_ready = w_idle & w_gnt_vld & w_gnt;

  assign w_in_x = w_gnt ? req1_x : req0_x;
  assign w_in_y = w_gnt ? req1_y : req0_y;
  assign w_div0 = (w_in_y == '0);
  // Quotient would not fit in 4 bits when the dividend's upper half >= divisor.
  assign w_ovf  = CHK_OVF && (w_in_x[DIVIDEND_W-1:DIVISOR_W] >= w_in_y);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rsp_nxt   = r_rsp;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_rsp_nxt.id = w_gnt;
          if (w_div0) begin
            w_state_nxt   = ST_RESP;
            w_rsp_nxt.q   = '1;
            w_rsp_nxt.r   = '0;
            w_rsp_nxt.err = ERR_DIV0;
          end else if (w_ovf) begin
            w_state_nxt   = ST_RESP;
            w_rsp_nxt.q   = '1;
            w_rsp_nxt.r   = '0;
            w_rsp_nxt.err = ERR_OVF;
          end else begin
            w_state_nxt = ST_SETTLE;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt   = ST_RESP;
          w_rsp_nxt.q   = arr_q;
          w_rsp_nxt.r   = arr_r;
          w_rsp_nxt.err = ERR_OK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rsp   <= w_rsp_nxt;
      // Operands stay on the array until the next accept.
      if (w_accept) begin
        r_x <= w_in_x;
        r_y <= w_in_y;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp.id;
  assign rsp_q     = r_rsp.q;
  assign rsp_r     = r_rsp.r;
  assign rsp_err   = r_rsp.err;
  assign busy      = (r_state != ST_IDLE);
  assign arr_x     = r_x;
  assign arr_y     = r_y;
  assign arr_bin   = '0;

endmodule
